// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Width and pointer-wrap helpers shared by the FIFO files.
// Revision : 1.0 - initial release
// ============================================================================

package fifo_pkg;

   // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1 states.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Explicit wrap so non-power-of-two depths never index past the array.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram
// Brief    : Simple dual-port storage array, registered write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================

module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : fifo_level
// Brief    : Parametrised synchronous FIFO with count, thresholds, sticky
//            errors and flush. Define FIFO_FWFT_EN for first-word fall-through.
// Revision : 1.0 - initial release
// ============================================================================

module fifo_level
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                          i_CLK,
   input  logic                          i_RESET,
   input  logic                          i_Clear,
   input  logic [DATA_WIDTH-1:0]         i_Data,
   input  logic                          i_Write_EN,
   input  logic                          i_Read_EN,
   output logic [DATA_WIDTH-1:0]         o_Data,
   output logic                          o_Read_Valid,
   output logic                          o_Empty,
   output logic                          o_Full,
   output logic                          o_Almost_Empty,
   output logic                          o_Almost_Full,
   output logic [cnt_width(DEPTH)-1:0]   o_Count,
   output logic                          o_Overflow,
   output logic                          o_Underflow
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  empty, full;
   logic                  rd_ok, wr_ok;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // A full FIFO still takes a write when the head pops on the same edge.
   assign rd_ok = i_Read_EN && !empty;
   assign wr_ok = i_Write_EN && (!full || rd_ok);

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (PW)
   ) u_ram (
      .i_clk   (i_CLK),
      .i_we    (wr_ok && !i_Clear),
      .i_waddr (wr_ptr_q),
      .i_wdata (i_Data),
      .i_raddr (rd_ptr_q),
      .o_rdata (ram_rdata)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      if (i_Clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
         end
         if (rd_ok) begin
            rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
         end
         if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
         end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
         end
         if (i_Write_EN && !wr_ok) begin
            ovf_d = 1'b1;
         end
         if (i_Read_EN && !rd_ok) begin
            udf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word is presented directly; a read simply acknowledges it.
   assign o_Data       = ram_rdata;
   assign o_Read_Valid = !empty;
`else
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;

   always_comb begin
      rvalid_d = rd_ok && !i_Clear;
      rdata_d  = rvalid_d ? ram_rdata : rdata_q;
   end

   always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign o_Data       = rdata_q;
   assign o_Read_Valid = rvalid_q;
`endif

   assign o_Empty        = empty;
   assign o_Full         = full;
   assign o_Almost_Empty = (count_q <= CW'(AEMPTY_THRESH));
   assign o_Almost_Full  = (count_q >= CW'(AFULL_THRESH));
   assign o_Count        = count_q;
   assign o_Overflow     = ovf_q;
   assign o_Underflow    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_level
// Brief    : Directed self-checking bench for fifo_level (depths 16, 5 and 4).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fifo_level;

   logic clk;
   int   n_chk  = 0;
   int   n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- DEPTH=16, AF=14, AE=2 ----------------
   logic       rst16, clr16, we16, re16;
   logic [7:0] din16, d16;
   logic       rv16, e16, f16, ae16, af16, ov16, un16;
   logic [4:0] cnt16;

   fifo_level #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u16 (
      .i_CLK(clk), .i_RESET(rst16), .i_Clear(clr16), .i_Data(din16),
      .i_Write_EN(we16), .i_Read_EN(re16), .o_Data(d16), .o_Read_Valid(rv16),
      .o_Empty(e16), .o_Full(f16), .o_Almost_Empty(ae16), .o_Almost_Full(af16),
      .o_Count(cnt16), .o_Overflow(ov16), .o_Underflow(un16));

   // ---------------- DEPTH=5 ----------------
   logic       rst5, clr5, we5, re5;
   logic [7:0] din5, d5;
   logic       rv5, e5, f5, ae5, af5, ov5, un5;
   logic [2:0] cnt5;

   fifo_level #(.DATA_WIDTH(8), .DEPTH(5)) u5 (
      .i_CLK(clk), .i_RESET(rst5), .i_Clear(clr5), .i_Data(din5),
      .i_Write_EN(we5), .i_Read_EN(re5), .o_Data(d5), .o_Read_Valid(rv5),
      .o_Empty(e5), .o_Full(f5), .o_Almost_Empty(ae5), .o_Almost_Full(af5),
      .o_Count(cnt5), .o_Overflow(ov5), .o_Underflow(un5));

   // ---------------- DEPTH=4 ----------------
   logic       rst4, clr4, we4, re4;
   logic [7:0] din4, d4;
   logic       rv4, e4, f4, ae4, af4, ov4, un4;
   logic [2:0] cnt4;

   fifo_level #(.DATA_WIDTH(8), .DEPTH(4)) u4 (
      .i_CLK(clk), .i_RESET(rst4), .i_Clear(clr4), .i_Data(din4),
      .i_Write_EN(we4), .i_Read_EN(re4), .o_Data(d4), .o_Read_Valid(rv4),
      .o_Empty(e4), .o_Full(f4), .o_Almost_Empty(ae4), .o_Almost_Full(af4),
      .o_Count(cnt4), .o_Overflow(ov4), .o_Underflow(un4));

   typedef struct {
      logic       clr, we, re;
      logic [7:0] din;
      logic [2:0] cnt;
      logic       full, empty, ovf, udf, rv;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write16(input logic [7:0] d);
      we16 = 1'b1; din16 = d; tick(); we16 = 1'b0;
   endtask

   task automatic read16(input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
      check("rd16_valid", 32'(rv16), 32'd1);
      check("rd16_data", 32'(d16), 32'(exp));
      re16 = 1'b1; tick(); re16 = 1'b0;
`else
      re16 = 1'b1; tick(); re16 = 1'b0;
      check("rd16_valid", 32'(rv16), 32'd1);
      check("rd16_data", 32'(d16), 32'(exp));
`endif
   endtask

   task automatic write5(input logic [7:0] d);
      we5 = 1'b1; din5 = d; tick(); we5 = 1'b0;
   endtask

   task automatic read5(input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
      check("rd5_data", 32'(d5), 32'(exp));
      re5 = 1'b1; tick(); re5 = 1'b0;
`else
      re5 = 1'b1; tick(); re5 = 1'b0;
      check("rd5_valid", 32'(rv5), 32'd1);
      check("rd5_data", 32'(d5), 32'(exp));
`endif
   endtask

   initial begin
      // clr, we, re, din | cnt, full, empty, ovf, udf, rv, dout
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h12, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h13, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h14, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h55, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h13};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h14};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h21, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h23, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h24, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h99, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h21};
      tbl[16] = '{1'b1, 1'b1, 1'b1, 8'h77, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h21};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h66, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h21};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66};

      {clr16, we16, re16, din16} = '0;
      {clr5,  we5,  re5,  din5 } = '0;
      {clr4,  we4,  re4,  din4 } = '0;
      rst16 = 1'b1; rst5 = 1'b1; rst4 = 1'b1;
      repeat (2) tick();

      // Reset state (held in reset, then one idle cycle after release)
      check("rst_count", 32'(cnt16), 32'd0);
      check("rst_empty", 32'(e16), 32'd1);
      check("rst_aempty", 32'(ae16), 32'd1);
      check("rst_full", 32'(f16), 32'd0);
      check("rst_afull", 32'(af16), 32'd0);
      check("rst_ovf", 32'(ov16), 32'd0);
      check("rst_udf", 32'(un16), 32'd0);
`ifndef FIFO_FWFT_EN
      check("rst_rvalid", 32'(rv16), 32'd0);
      check("rst_data", 32'(d16), 32'd0);
`else
      check("rst_rvalid", 32'(rv16), 32'd0);
`endif
      rst16 = 1'b0; rst5 = 1'b0; rst4 = 1'b0;
      tick();
      check("post_rst_count", 32'(cnt16), 32'd0);

      // DEPTH=4 table: full+simultaneous r/w, errors, clear
      for (int i = 0; i < 19; i++) begin
         clr4 = tbl[i].clr; we4 = tbl[i].we; re4 = tbl[i].re; din4 = tbl[i].din;
         tick();
         check($sformatf("v%0d_count", i), 32'(cnt4), 32'(tbl[i].cnt));
         check($sformatf("v%0d_full", i), 32'(f4), 32'(tbl[i].full));
         check($sformatf("v%0d_empty", i), 32'(e4), 32'(tbl[i].empty));
         check($sformatf("v%0d_ovf", i), 32'(ov4), 32'(tbl[i].ovf));
         check($sformatf("v%0d_udf", i), 32'(un4), 32'(tbl[i].udf));
`ifdef FIFO_FWFT_EN
         check($sformatf("v%0d_rvalid", i), 32'(rv4), 32'(!tbl[i].empty));
`else
         check($sformatf("v%0d_rvalid", i), 32'(rv4), 32'(tbl[i].rv));
         check($sformatf("v%0d_data", i), 32'(d4), 32'(tbl[i].dout));
`endif
      end
      {clr4, we4, re4} = '0;

      // DEPTH=16 fill with threshold checks, then drain in order
      for (int i = 1; i <= 16; i++) begin
         write16(8'(i));
         if (i == 2)  check("ae_at_2", 32'(ae16), 32'd1);
         if (i == 3)  check("ae_at_3", 32'(ae16), 32'd0);
         if (i == 13) check("af_at_13", 32'(af16), 32'd0);
         if (i == 14) check("af_at_14", 32'(af16), 32'd1);
      end
      check("fill_full", 32'(f16), 32'd1);
      check("fill_count", 32'(cnt16), 32'd16);
      for (int i = 1; i <= 16; i++) read16(8'(i));
      check("drain_empty", 32'(e16), 32'd1);
      check("drain_ovf", 32'(ov16), 32'd0);
      check("drain_udf", 32'(un16), 32'd0);

      // DEPTH=5 pointer wrap
      for (int i = 1; i <= 3; i++) write5(8'(i));
      for (int i = 1; i <= 3; i++) read5(8'(i));
      for (int i = 0; i < 5; i++) write5(8'hA0 + 8'(i));
      check("d5_full", 32'(f5), 32'd1);
      check("d5_count_full", 32'(cnt5), 32'd5);
      for (int i = 0; i < 5; i++) read5(8'hA0 + 8'(i));
      check("d5_count_end", 32'(cnt5), 32'd0);
      check("d5_empty", 32'(e5), 32'd1);
      check("d5_errs", 32'({ov5, un5}), 32'd0);

      // Asynchronous reset in the middle of a write burst
      we16 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         din16 = 8'h30 + 8'(i);
         tick();
      end
      check("burst_count", 32'(cnt16), 32'd7);
      #2 rst16 = 1'b1;
      #1;
      check("async_rst_count", 32'(cnt16), 32'd0);
      check("async_rst_empty", 32'(e16), 32'd1);
      check("async_rst_aempty", 32'(ae16), 32'd1);
      check("async_rst_full", 32'({f16, af16}), 32'd0);
      check("async_rst_rvalid", 32'(rv16), 32'd0);
      @(negedge clk);
      we16 = 1'b0; rst16 = 1'b0;
      tick();
      check("after_rst_count", 32'(cnt16), 32'd0);

      // First write after reset: head visibility
      write16(8'h5A);
`ifdef FIFO_FWFT_EN
      check("fwft_head_valid", 32'(rv16), 32'd1);
      check("fwft_head_data", 32'(d16), 32'h5A);
`else
      check("reg_no_valid_on_write", 32'(rv16), 32'd0);
`endif
      read16(8'h5A);
      check("final_empty", 32'(e16), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised single-clock synchronous FIFO. Successor to the basic 8x16 FIFO.
- Adds:
  - non-power-of-two depth
  - simultaneous read/write when full
  - programmable almost-full and almost-empty flags
  - a live occupancy count
  - sticky overflow and underflow error flags
  - a synchronous flush
- Sits between producer and consumer logic inside one clock domain, e.g. UART RX/TX buffering or keyboard scan queues.

Parameters:
- DATA_WIDTH, 8, word width in bits (≥1).
- DEPTH, 16, number of entries (≥2, any integer, power of two not required).
- AFULL_THRESH, DEPTH-2, o_Almost_Full asserts when count ≥ this value (1..DEPTH).
- AEMPTY_THRESH, 2, o_Almost_Empty asserts when count ≤ this value (0..DEPTH-1).

Ports:
- i_CLK  in  1  system clock, rising edge.
- i_RESET  in  1  asynchronous, active-high reset.
- i_Clear  in  1  synchronous flush.
- i_Data  in  DATA_WIDTH  write data.
- i_Write_EN  in  1  write request.
- i_Read_EN  in  1  read/pop request.
- o_Data  out  DATA_WIDTH  read data.
- o_Read_Valid  out  1  o_Data holds a newly read word.
- o_Empty  out  1  count == 0.
- o_Full  out  1  count == DEPTH.
- o_Almost_Empty  out  1  count ≤ AEMPTY_THRESH.
- o_Almost_Full  out  1  count ≥ AFULL_THRESH.
- o_Count  out  CW  occupancy, where CW = $clog2(DEPTH+1).
- o_Overflow  out  1  sticky: a write was rejected.
- o_Underflow  out  1  sticky: a read was rejected.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-high: i_CLK, i_RESET.
  - Reset is asserted asynchronously and released synchronously by the instantiating logic.
- Reset values:
  - Pointers, count, o_Data, o_Read_Valid, o_Overflow and o_Underflow are 0.
  - Consequently o_Empty=1, o_Almost_Empty=1, o_Full=0, and o_Almost_Full=0 (given AFULL_THRESH ≥ 1).
  - Reset mid-operation discards all contents immediately.
  - Memory contents are not reset.
- Priority: i_RESET > i_Clear > normal operation.
- i_Clear:
  - Zeroes the pointers, count, o_Read_Valid and both sticky flags on the next edge.
  - Any i_Write_EN or i_Read_EN in the same cycle is ignored.
  - Does not set the error flags.
  - o_Data holds its value.
- Accept rules, evaluated on registered state at the edge:
  - rd_ok = i_Read_EN && !o_Empty.
  - wr_ok = i_Write_EN && (!o_Full || rd_ok). A write while full is accepted only if a read pops in the same cycle.
  - Empty + read + write: the read is rejected, the write is accepted.
- Count update:
  - wr_ok only: count +1.
  - rd_ok only: count −1.
  - both or neither: count unchanged.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits.
  - Increments on accept; explicit wrap DEPTH-1 → 0, never relying on natural overflow.
- Errors:
  - i_Write_EN && !wr_ok sets o_Overflow.
  - i_Read_EN && !rd_ok sets o_Underflow.
  - Both stay set until i_Clear or reset.
- Read path (default):
  - rd_ok at edge N: o_Data = mem[rd_ptr] after edge N, and o_Read_Valid=1 for exactly the cycle following edge N.
  - Otherwise o_Read_Valid=0 and o_Data holds its last value.
- Flags:
  - All flags are decoded combinationally from the registered count.
  - Flags update in the cycle after the accepting edge.
- Write-to-read latency: a word written at edge N can be read at edge N+1, with data visible after N+1.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - o_Data = mem[rd_ptr] combinationally.
  - o_Read_Valid = !o_Empty.
  - i_Read_EN acknowledges/pops the current head.
  - The head is visible the cycle after the write edge.
  - Reset, clear and error rules are unchanged.
- Undefined: the registered one-cycle-latency read path above.

Decomposition:
- Package fifo_pkg holds:
  - the count-width function: clog2 of DEPTH+1
  - the pointer-width function
  - a pointer-wrap increment function parametrised by DEPTH
- Sub-module fifo_ram:
  - simple dual-port array with registered write
  - read port combinational, so one array serves both read modes
- fifo_level owns pointers, count, flags and errors.

Test Plan:
- Reset with DEPTH=16: write 0x01..0x10 → o_Full=1 and o_Count=16. Then read 16 → data order 0x01..0x10, o_Empty=1, no error flags.
- DEPTH=5 wrap: write 3, read 3, write 5 (0xA0..0xA4), read 5 → order A0..A4, pointers wrap at 4, o_Count returns to 0.
- Full + simultaneous read/write with DEPTH=4 (0x11..0x14 stored):
  - read + write 0x55 → o_Full stays 1, o_Overflow=0.
  - then read 4 → 0x12, 0x13, 0x14, 0x55.
- Errors:
  - write while full without read → o_Overflow=1, content unchanged.
  - read while empty → o_Underflow=1.
  - i_Clear → both 0 and o_Count=0.
- Thresholds with DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2:
  - count 2 → AE=1.
  - count 3 → AE=0.
  - count 13 → AF=0.
  - count 14 → AF=1.
- Reset and clear during traffic:
  - assert i_RESET mid-burst at count 7 → flags immediately at reset values, o_Count=0.
  - repeat with FIFO_FWFT_EN defined → head data visible with o_Read_Valid=1 one cycle after the first write.
